// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard, forwarding and stall control for the 5-stage MIPS pipeline.
// It computes the rs/rt forwarding selects and the store-data forward. It also
// inserts load-use bubbles, flushes ID after taken jumps/branches and freezes the
// pipe on ROM/RAM waits. A jump seen during a freeze is deferred to the resume cycle.
// stall_cycles counts every cycle that carries a stall, freeze or flush.
// Optional feature macro: HAZARD_DEBUG_STEP_EN adds single-step debug control
// through the debug_en and debug_step inputs.
module pipe_hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_is_store,
  input  logic [REG_AW-1:0] exe_waddr,
  input  logic              exe_wen,
  input  logic              exe_is_load,
  input  logic [REG_AW-1:0] mem_waddr,
  input  logic              mem_wen,
  input  logic              mem_is_load,
  input  logic              jump_en,
  input  logic              rom_stall,
  input  logic              ram_stall,
`ifdef HAZARD_DEBUG_STEP_EN
  input  logic              debug_en,
  input  logic              debug_step,
`endif
  output logic [1:0]        fwd_a_ctrl,
  output logic [1:0]        fwd_b_ctrl,
  output logic              fwd_m,
  output logic              if_en,
  output logic              id_en,
  output logic              exe_en,
  output logic              mem_en,
  output logic              wb_en,
  output logic              if_rst,
  output logic              id_rst,
  output logic              exe_rst,
  output logic              mem_rst,
  output logic              wb_rst,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int FCW = $clog2(FLUSH_DEPTH + 1);
  localparam logic [FCW-1:0] FLUSH_RELOAD = FCW'(FLUSH_DEPTH - 1);
  localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_FLUSH = 2'b01,
    ST_MWAIT = 2'b10
  } state_t;

  state_t           state_r;
  state_t           nxt_state_s;
  logic [FCW-1:0]   flush_cnt_r;
  logic [FCW-1:0]   nxt_cnt_s;
  logic             pend_jump_r;
  logic             nxt_pend_s;
  logic             adv_s;
  logic             load_hz_s;
  logic             stall_event_s;
  logic             start_flush_s;
  logic             step_flush_s;
  logic             run_eval_s;
  logic [CNT_W-1:0] stall_cnt_r;
`ifdef HAZARD_DEBUG_STEP_EN
  logic             step_prev_r;
`endif

  // Select the forwarding source for one ID operand. A non-load EXE result wins over MEM.
  function automatic logic [1:0] fwd_sel(input logic used, input logic [REG_AW-1:0] src,
                                         input logic [REG_AW-1:0] e_addr, input logic e_wen,
                                         input logic e_load, input logic [REG_AW-1:0] m_addr,
                                         input logic m_wen, input logic m_load);
    logic [1:0] sel;
    if (used && (src != REG_ZERO)) begin
      if ((src == e_addr) && e_wen && !e_load) begin
        sel = 2'b01;
      end else if ((src == m_addr) && m_wen) begin
        sel = m_load ? 2'b11 : 2'b10;
      end else begin
        sel = 2'b00;
      end
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Detect load-use hazards. Store data behind a load is forwarded later and does not stall.
  always_comb begin
    load_hz_s = exe_is_load && exe_wen && (exe_waddr != REG_ZERO) &&
                ((id_rs_used && (id_rs_addr == exe_waddr)) ||
                 (id_rt_used && (id_rt_addr == exe_waddr) && !id_is_store));
  end

  // Hazard FSM next-state logic, stage enables/clears and forwarding outputs.
  always_comb begin
    if_en         = 1'b1;
    id_en         = 1'b1;
    exe_en        = 1'b1;
    mem_en        = 1'b1;
    wb_en         = 1'b1;
    if_rst        = 1'b0;
    id_rst        = 1'b0;
    exe_rst       = 1'b0;
    mem_rst       = 1'b0;
    wb_rst        = 1'b0;
    fwd_a_ctrl    = fwd_sel(id_rs_used, id_rs_addr, exe_waddr, exe_wen, exe_is_load,
                            mem_waddr, mem_wen, mem_is_load);
    fwd_b_ctrl    = fwd_sel(id_rt_used, id_rt_addr, exe_waddr, exe_wen, exe_is_load,
                            mem_waddr, mem_wen, mem_is_load);
    fwd_m         = id_is_store && id_rt_used && exe_is_load && exe_wen &&
                    (exe_waddr == id_rt_addr) && (id_rt_addr != REG_ZERO);
    nxt_state_s   = state_r;
    nxt_cnt_s     = flush_cnt_r;
    nxt_pend_s    = pend_jump_r;
    adv_s         = 1'b1;
    start_flush_s = 1'b0;
    step_flush_s  = 1'b0;
    run_eval_s    = 1'b0;

    if (rst) begin
      if_rst     = 1'b1;
      id_rst     = 1'b1;
      exe_rst    = 1'b1;
      mem_rst    = 1'b1;
      wb_rst     = 1'b1;
      fwd_a_ctrl = 2'b00;
      fwd_b_ctrl = 2'b00;
      fwd_m      = 1'b0;
`ifdef HAZARD_DEBUG_STEP_EN
    end else if (debug_en && !(debug_step && !step_prev_r)) begin
      // Debug hold: the pipe and all internal counters stay frozen.
      if_en  = 1'b0;
      id_en  = 1'b0;
      exe_en = 1'b0;
      mem_en = 1'b0;
      wb_en  = 1'b0;
      adv_s  = 1'b0;
`endif
    end else if (rom_stall || ram_stall) begin
      if_en       = 1'b0;
      id_en       = 1'b0;
      exe_en      = 1'b0;
      mem_en      = 1'b0;
      wb_en       = 1'b0;
      nxt_state_s = ST_MWAIT;
      if (jump_en) begin
        nxt_pend_s = 1'b1;
      end else begin
        nxt_pend_s = pend_jump_r;
      end
    end else begin
      // Resume from a freeze: a deferred jump restarts the flush. A flush cut short
      // by the freeze continues, and otherwise the cycle is evaluated like RUN.
      case (state_r)
        ST_RUN: begin
          run_eval_s = 1'b1;
        end
        ST_FLUSH: begin
          step_flush_s = 1'b1;
        end
        ST_MWAIT: begin
          if (pend_jump_r) begin
            start_flush_s = 1'b1;
          end else if (flush_cnt_r != {FCW{1'b0}}) begin
            step_flush_s = 1'b1;
          end else begin
            run_eval_s = 1'b1;
          end
        end
        default: begin
          nxt_state_s = ST_RUN;
          nxt_cnt_s   = {FCW{1'b0}};
        end
      endcase

      if (run_eval_s && load_hz_s) begin
        if_en       = 1'b0;
        id_en       = 1'b0;
        exe_rst     = 1'b1;
        nxt_state_s = ST_RUN;
      end else if ((run_eval_s && jump_en) || start_flush_s) begin
        id_rst     = 1'b1;
        nxt_pend_s = 1'b0;
        nxt_cnt_s  = FLUSH_RELOAD;
        if (FLUSH_RELOAD != {FCW{1'b0}}) begin
          nxt_state_s = ST_FLUSH;
        end else begin
          nxt_state_s = ST_RUN;
        end
      end else if (step_flush_s) begin
        id_rst = 1'b1;
        if (flush_cnt_r > FCW'(1)) begin
          nxt_cnt_s   = flush_cnt_r - FCW'(1);
          nxt_state_s = ST_FLUSH;
        end else begin
          nxt_cnt_s   = {FCW{1'b0}};
          nxt_state_s = ST_RUN;
        end
      end else if (run_eval_s) begin
        nxt_state_s = ST_RUN;
      end else begin
        nxt_state_s = ST_RUN;
        nxt_cnt_s   = {FCW{1'b0}};
      end
    end

    stall_event_s = !(if_en && id_en && exe_en && mem_en && wb_en) || id_rst || exe_rst;
  end

  // Register the FSM state, the flush counter, the deferred jump and the stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_RUN;
      flush_cnt_r <= {FCW{1'b0}};
      pend_jump_r <= 1'b0;
      stall_cnt_r <= {CNT_W{1'b0}};
`ifdef HAZARD_DEBUG_STEP_EN
      step_prev_r <= 1'b0;
`endif
    end else begin
`ifdef HAZARD_DEBUG_STEP_EN
      step_prev_r <= debug_step;
`endif
      if (adv_s) begin
        state_r     <= nxt_state_s;
        flush_cnt_r <= nxt_cnt_s;
        pend_jump_r <= nxt_pend_s;
        if (stall_event_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
          stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign stall_cycles = stall_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors for pipe_hazard_ctrl. Two instances share
// the stimulus: dut1 uses FLUSH_DEPTH=1 and dut3 uses FLUSH_DEPTH=3.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs_addr, id_rt_addr, exe_waddr, mem_waddr;
  logic       id_rs_used, id_rt_used, id_is_store;
  logic       exe_wen, exe_is_load, mem_wen, mem_is_load;
  logic       jump_en, rom_stall, ram_stall;

  logic [1:0]  fa1, fb1, fa3, fb3;
  logic        fm1, fm3;
  logic [4:0]  en1, rs1, en3, rs3;  // {if,id,exe,mem,wb}
  logic [31:0] sc1, sc3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(5), .FLUSH_DEPTH(1), .CNT_W(32)) dut1 (
    .clk(clk), .rst(rst),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_is_store(id_is_store),
    .exe_waddr(exe_waddr), .exe_wen(exe_wen), .exe_is_load(exe_is_load),
    .mem_waddr(mem_waddr), .mem_wen(mem_wen), .mem_is_load(mem_is_load),
    .jump_en(jump_en), .rom_stall(rom_stall), .ram_stall(ram_stall),
`ifdef HAZARD_DEBUG_STEP_EN
    .debug_en(1'b0), .debug_step(1'b0),
`endif
    .fwd_a_ctrl(fa1), .fwd_b_ctrl(fb1), .fwd_m(fm1),
    .if_en(en1[4]), .id_en(en1[3]), .exe_en(en1[2]), .mem_en(en1[1]), .wb_en(en1[0]),
    .if_rst(rs1[4]), .id_rst(rs1[3]), .exe_rst(rs1[2]), .mem_rst(rs1[1]), .wb_rst(rs1[0]),
    .stall_cycles(sc1)
  );

  pipe_hazard_ctrl #(.REG_AW(5), .FLUSH_DEPTH(3), .CNT_W(32)) dut3 (
    .clk(clk), .rst(rst),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_is_store(id_is_store),
    .exe_waddr(exe_waddr), .exe_wen(exe_wen), .exe_is_load(exe_is_load),
    .mem_waddr(mem_waddr), .mem_wen(mem_wen), .mem_is_load(mem_is_load),
    .jump_en(jump_en), .rom_stall(rom_stall), .ram_stall(ram_stall),
`ifdef HAZARD_DEBUG_STEP_EN
    .debug_en(1'b0), .debug_step(1'b0),
`endif
    .fwd_a_ctrl(fa3), .fwd_b_ctrl(fb3), .fwd_m(fm3),
    .if_en(en3[4]), .id_en(en3[3]), .exe_en(en3[2]), .mem_en(en3[1]), .wb_en(en3[0]),
    .if_rst(rs3[4]), .id_rst(rs3[3]), .exe_rst(rs3[2]), .mem_rst(rs3[1]), .wb_rst(rs3[0]),
    .stall_cycles(sc3)
  );

  typedef struct {
    logic [4:0] rs, rt;
    logic       rsu, rtu, st;
    logic [4:0] ew;
    logic       ewen, eld;
    logic [4:0] mw;
    logic       mwen, mld;
    logic [1:0] fa, fb;
    logic       fm, stl;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    id_rs_addr = 5'd0; id_rt_addr = 5'd0;
    id_rs_used = 1'b0; id_rt_used = 1'b0; id_is_store = 1'b0;
    exe_waddr = 5'd0; exe_wen = 1'b0; exe_is_load = 1'b0;
    mem_waddr = 5'd0; mem_wen = 1'b0; mem_is_load = 1'b0;
    jump_en = 1'b0; rom_stall = 1'b0; ram_stall = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    int n_stall;
    // rs rt rsu rtu st | ew ewen eld | mw mwen mld | fa fb fm stl
    vecs[0] = '{5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1};
    vecs[1] = '{5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 2'b11, 2'b00, 1'b0, 1'b0};
    vecs[2] = '{5'd1, 5'd4, 1'b1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
    vecs[3] = '{5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0};
    vecs[4] = '{5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
    vecs[5] = '{5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0};
    vecs[6] = '{5'd8, 5'd9, 1'b1, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1};
    vecs[7] = '{5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0};
    vecs[8] = '{5'd6, 5'd6, 1'b0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0};

    // Reset state
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    chk("rst_clears", {27'd0, rs1}, 32'h1f);
    chk("rst_enables", {27'd0, en1}, 32'h1f);
    chk("rst_fwd", {28'd0, fa1, fb1}, 32'h0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cnt", sc1, 32'd0);
    chk("post_rst_clears", {27'd0, rs1}, 32'h0);
    chk("post_rst_enables", {27'd0, en1}, 32'h1f);
    next_cycle();

    // Table of single-cycle forwarding / load-use vectors
    do_reset();
    n_stall = 0;
    for (int i = 0; i < 9; i++) begin
      id_rs_addr = vecs[i].rs;  id_rt_addr = vecs[i].rt;
      id_rs_used = vecs[i].rsu; id_rt_used = vecs[i].rtu; id_is_store = vecs[i].st;
      exe_waddr = vecs[i].ew; exe_wen = vecs[i].ewen; exe_is_load = vecs[i].eld;
      mem_waddr = vecs[i].mw; mem_wen = vecs[i].mwen; mem_is_load = vecs[i].mld;
      @(negedge clk);
      chk($sformatf("vec%0d_fwd_a", i), {30'd0, fa1}, {30'd0, vecs[i].fa});
      chk($sformatf("vec%0d_fwd_b", i), {30'd0, fb1}, {30'd0, vecs[i].fb});
      chk($sformatf("vec%0d_fwd_m", i), {31'd0, fm1}, {31'd0, vecs[i].fm});
      chk($sformatf("vec%0d_if_id_en", i), {30'd0, en1[4:3]},
          vecs[i].stl ? 32'd0 : 32'd3);
      chk($sformatf("vec%0d_exe_rst", i), {31'd0, rs1[2]}, {31'd0, vecs[i].stl});
      if (i == 1) chk("load_use_cnt", sc1, 32'd1);
      if (vecs[i].stl) n_stall++;
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    chk("table_stall_cnt", sc1, n_stall);
    next_cycle();

    // FLUSH_DEPTH=3: one jump pulse gives exactly 3 id_rst cycles; later jumps ignored
    do_reset();
    for (int c = 0; c < 5; c++) begin
      jump_en = (c == 0 || c == 1 || c == 2) ? 1'b1 : 1'b0;
      @(negedge clk);
      chk($sformatf("flush3_c%0d_id_rst", c), {31'd0, rs3[3]}, (c < 3) ? 32'd1 : 32'd0);
      next_cycle();
      jump_en = 1'b0;
    end
    @(negedge clk);
    chk("flush3_cnt", sc3, 32'd3);
    next_cycle();

    // ram_stall for 4 cycles with a jump in the 2nd, deferred flush on exit
    do_reset();
    for (int c = 0; c < 4; c++) begin
      ram_stall = 1'b1;
      jump_en = (c == 1) ? 1'b1 : 1'b0;
      @(negedge clk);
      chk($sformatf("mwait_c%0d_en", c), {27'd0, en1}, 32'd0);
      chk($sformatf("mwait_c%0d_id_rst", c), {31'd0, rs1[3]}, 32'd0);
      next_cycle();
    end
    ram_stall = 1'b0;
    jump_en = 1'b0;
    @(negedge clk);
    chk("mwait_exit_id_rst", {31'd0, rs1[3]}, 32'd1);
    chk("mwait_exit_en", {27'd0, en1}, 32'h1f);
    next_cycle();
    @(negedge clk);
    chk("mwait_after_id_rst", {31'd0, rs1[3]}, 32'd0);
    chk("mwait_cnt_d1", sc1, 32'd5);
    chk("mwait_d3_flush_cont", {31'd0, rs3[3]}, 32'd1);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("mwait_cnt_d3", sc3, 32'd7);
    chk("mwait_d3_done", {31'd0, rs3[3]}, 32'd0);
    next_cycle();

    // rst in the middle of a FLUSH
    do_reset();
    jump_en = 1'b1;
    next_cycle();
    jump_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midflush_rst_clears", {27'd0, rs3}, 32'h1f);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("midflush_id_rst", {31'd0, rs3[3]}, 32'd0);
    chk("midflush_cnt", sc3, 32'd0);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
